// File: rtl/sequential_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero completes immediately with an all-ones quotient and the dividend as remainder.
module sequential_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_accept;
    logic          w_last;
    logic [N-1:0]  r_dvd;
    logic [N-1:0]  r_dsr;
    logic [N-1:0]  r_quo;
    logic [N:0]    r_rem;
    logic [CW-1:0] r_cnt;
    logic [N+1:0]  w_trial;
    logic [N+1:0]  w_diff;
    logic          w_qbit;
    logic [N:0]    w_rem_next;

    // Trial subtraction for the current step; the extra top bit makes the sign unambiguous
    always_comb begin
        w_trial    = {r_rem, r_dvd[N-1]};
        w_diff     = w_trial - {2'b00, r_dsr};
        w_qbit     = ~w_diff[N+1];
        w_rem_next = w_trial[N:0];
        if (w_qbit) begin
            w_rem_next = w_diff[N:0];
        end else begin
            w_rem_next = w_trial[N:0];
        end
    end

    // Next-state logic; start is only honoured outside RUN
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = (r_cnt == {CW{1'b0}});
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (divisor == {N{1'b0}}) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_RUN;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RUN;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register with busy/done registered alongside so they track the state exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_next;
            busy    <= (w_next == S_RUN);
            done    <= (w_next == S_DONE);
        end
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd       <= {N{1'b0}};
            r_dsr       <= {N{1'b0}};
            r_quo       <= {N{1'b0}};
            r_rem       <= {(N+1){1'b0}};
            r_cnt       <= {CW{1'b0}};
            quotient    <= {N{1'b0}};
            remainder   <= {N{1'b0}};
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_dvd <= dividend;
            r_dsr <= divisor;
            r_quo <= {N{1'b0}};
            r_rem <= {(N+1){1'b0}};
            r_cnt <= CW'(N - 1);
            if (divisor == {N{1'b0}}) begin
                quotient    <= {N{1'b1}};
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= quotient;
                remainder   <= remainder;
                div_by_zero <= div_by_zero;
            end
        end else if (r_state == S_RUN) begin
            r_dvd <= {r_dvd[N-2:0], 1'b0};
            r_rem <= w_rem_next;
            r_quo <= {r_quo[N-2:0], w_qbit};
            r_cnt <= r_cnt - CW'(1);
            // Results become visible only on the final step, never mid-iteration
            if (w_last) begin
                quotient    <= {r_quo[N-2:0], w_qbit};
                remainder   <= w_rem_next[N-1:0];
                div_by_zero <= 1'b0;
            end else begin
                quotient    <= quotient;
                remainder   <= remainder;
                div_by_zero <= div_by_zero;
            end
        end else begin
            r_dvd       <= r_dvd;
            r_dsr       <= r_dsr;
            r_quo       <= r_quo;
            r_rem       <= r_rem;
            r_cnt       <= r_cnt;
            quotient    <= quotient;
            remainder   <= remainder;
            div_by_zero <= div_by_zero;
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Directed-vector bench for sequential_divider (N=8) plus an exhaustive N=4 sweep.
module tb_sequential_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend, divisor, quotient, remainder;
    logic       busy, done, dbz;

    logic       s4_start;
    logic [3:0] s4_a, s4_b, s4_q, s4_r;
    logic       s4_busy, s4_done, s4_dbz;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    sequential_divider #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(dbz)
    );

    sequential_divider #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .dividend(s4_a), .divisor(s4_b),
        .busy(s4_busy), .done(s4_done), .quotient(s4_q), .remainder(s4_r),
        .div_by_zero(s4_dbz)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start a division and wait (bounded) for done; also watch busy and output stability
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] pq,
                        input logic [7:0] pr, output int lat, output int bcnt, output int unstable);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; bcnt = 0; unstable = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (quotient !== pq || remainder !== pr) unstable++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bc, un, bad;
        logic [7:0] prev_q, prev_r;

        tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9};
        tbl[1] = '{8'd5,   8'd0,   8'd255, 8'd5,   1'b1, 1};
        tbl[2] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
        tbl[3] = '{8'd3,   8'd10,  8'd0,   8'd3,   1'b0, 9};
        tbl[4] = '{8'd200, 8'd200, 8'd1,   8'd0,   1'b0, 9};
        tbl[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
        tbl[6] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9};
        tbl[7] = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 9};
        tbl[8] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1, 1};
        tbl[9] = '{8'd250, 8'd3,   8'd83,  8'd1,   1'b0, 9};

        rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        s4_start = 1'b0; s4_a = 4'd0; s4_b = 4'd0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_q", quotient, 0);
        chk("reset_r", remainder, 0);
        chk("reset_dbz", dbz, 0);
        @(negedge clk);
        rst = 1'b0;

        prev_q = 8'd0; prev_r = 8'd0;
        for (int i = 0; i < 10; i++) begin
            run8(tbl[i].a, tbl[i].b, prev_q, prev_r, lat, bc, un);
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_q", i), quotient, tbl[i].q);
            chk($sformatf("v%0d_r", i), remainder, tbl[i].r);
            chk($sformatf("v%0d_dbz", i), dbz, tbl[i].z);
            chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_busy_cycles", i), bc, tbl[i].lat - 1);
            chk($sformatf("v%0d_stable", i), un, 0);
            prev_q = tbl[i].q; prev_r = tbl[i].r;
        end
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_not_busy", busy, 0);

        // Second start mid-RUN must be ignored
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(5, lat);
        chk("ignore_lat", lat, 9);
        chk("ignore_q", quotient, 14);
        chk("ignore_r", remainder, 2);
        @(posedge clk); #1;

        // start held through DONE chains straight into the next division
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1;
        dividend = 8'd50; divisor = 8'd3;
        wait_done(1, lat);
        chk("chain1_lat", lat, 9);
        chk("chain1_q", quotient, 14);
        chk("chain1_r", remainder, 2);
        lat = 0; bc = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (busy) bc++;
        end while (!done && lat < 40);
        start = 1'b0;
        chk("chain2_lat", lat, 9);
        chk("chain2_busy", bc, 8);
        chk("chain2_q", quotient, 16);
        chk("chain2_r", remainder, 2);

        // Asynchronous reset between edges in the middle of RUN
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_q", quotient, 0);
        chk("arst_r", remainder, 0);
        chk("arst_dbz", dbz, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) bad++;
        end
        chk("no_done_after_reset", bad, 0);

        // Start is accepted on the first edge with reset low
        @(negedge clk);
        rst = 1'b1; start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("first_edge_busy", busy, 1);
        wait_done(1, lat);
        chk("first_edge_lat", lat, 9);
        chk("first_edge_q", quotient, 28);
        chk("first_edge_r", remainder, 4);

        // Exhaustive N=4 sweep against an arithmetic model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(negedge clk);
                s4_start = 1'b1; s4_a = a[3:0]; s4_b = b[3:0];
                @(posedge clk); #1;
                s4_start = 1'b0;
                lat = 1;
                while (!s4_done && lat < 20) begin
                    @(posedge clk); #1;
                    lat++;
                end
                chk($sformatf("n4_%0d_%0d_done", a, b), s4_done, 1);
                chk($sformatf("n4_%0d_%0d_q", a, b), s4_q, (b == 0) ? 15 : a / b);
                chk($sformatf("n4_%0d_%0d_r", a, b), s4_r, (b == 0) ? a : a % b);
                chk($sformatf("n4_%0d_%0d_dbz", a, b), s4_dbz, (b == 0) ? 1 : 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 SHALL have parameter N, default 8, giving the operand/result width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a division; sampled on the rising edge of clk.
REQ-005 SHALL have port dividend  input  N  unsigned numerator; sampled with start.
REQ-006 SHALL have port divisor  input  N  unsigned denominator; sampled with start.
REQ-007 SHALL have port busy  output  1  high while a division is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-009 SHALL have port quotient  output  N  unsigned quotient of the last completed division.
REQ-010 SHALL have port remainder  output  N  unsigned remainder of the last completed division.
REQ-011 SHALL have port div_by_zero  output  1  high when the last completed division had divisor 0.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE or DONE with start=1, capture dividend and divisor into internal registers and move to RUN (divisor != 0) or DONE (divisor == 0).
REQ-014 SHALL ignore start while in RUN; captured operands are unaffected by input changes after the capture edge.
REQ-015 SHALL, in RUN, perform restoring division: one quotient bit per cycle, MSB first, for exactly N cycles under a step counter counting N-1 down to 0.
REQ-016 SHALL, per step: form the trial value {partial_remainder[N-1:0], next dividend bit} (N+1 bits); subtract the zero-extended divisor; if the result is non-negative, keep it and set the quotient bit to 1; otherwise keep the unsubtracted value and set the bit to 0.
REQ-017 SHALL hold the partial remainder in N+1 bits so no step overflows for any divisor up to 2^N-1.
REQ-018 SHALL, after the step with counter 0, move to DONE and load quotient/remainder output registers in the same edge.
REQ-019 SHALL hold busy=1 exactly in RUN; done=1 exactly in DONE; DONE lasts one cycle and returns to IDLE unless start=1 (REQ-013).
REQ-020 SHALL give latency: done asserted on the cycle N+1 clocks after the start capture edge for nonzero divisor; 1 clock after for zero divisor.
REQ-021 SHALL, for divisor 0: quotient = all ones (2^N-1), remainder = dividend, div_by_zero=1; no RUN cycles.
REQ-022 SHALL clear div_by_zero when a nonzero-divisor division completes.
REQ-023 SHALL hold quotient, remainder and div_by_zero stable from their load edge until the next completion; intermediate RUN values never appear on them.
REQ-024 SHALL give results satisfying dividend == quotient*divisor + remainder and remainder < divisor for every nonzero divisor, including dividend < divisor (quotient 0, remainder dividend) and dividend == divisor (quotient 1, remainder 0).

Reset
REQ-025 SHALL, on rst=1, immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter and internal registers 0, regardless of clk.
REQ-026 SHALL abandon any in-progress division on reset; no done pulse follows reset release until a new start is accepted.
REQ-027 SHALL accept start on the first rising edge at which rst is low.

Verification
REQ-028 SHALL pass, N=8: start with 100/7 -> busy for 8 cycles, done on cycle 9, quotient=14, remainder=2, div_by_zero=0.
REQ-029 SHALL pass, N=8: 5/0 -> done 1 cycle after start, busy never high, quotient=255, remainder=5, div_by_zero=1; following 255/1 -> quotient=255, remainder=0, div_by_zero=0.
REQ-030 SHALL pass, N=8: 3/10 -> quotient=0, remainder=3; 200/200 -> quotient=1, remainder=0; 255/255 -> quotient=1, remainder=0.
REQ-031 SHALL pass: start 100/7, pulse start with 50/3 on RUN cycle 4 -> second request ignored, result 14/2.
REQ-032 SHALL pass: start held high through DONE after 100/7 with inputs 50/3 -> done pulses for 14/2, then 9 cycles later for 16/2 without IDLE between.
REQ-033 SHALL pass: rst asserted mid-RUN between clock edges -> all outputs 0 asynchronously, no done pulse after release; exhaustive N=4 sweep of all 256 operand pairs matches REQ-021/REQ-024.
